// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, one outstanding imem request, 2-entry {pc,instr} FIFO to decode (first instr 3 cycles after reset).
// Decode backpressure stops new requests once FIFO+outstanding fill; FETCH_MISALIGN_TRAP_EN adds the misalign_err trap.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  input  logic        pc_src,
  input  logic [31:0] branch_target
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, issued_pc, target;
  logic [31:0] pc0, pc1, in0, in1;
  logic [1:0]  count, count_after;
  logic        push, pop, still_out, bad_tgt, blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target  = branch_target;
  assign bad_tgt = |branch_target[1:0];
  assign blocked = misalign_err;
`else
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^branch_target[1:0];
  assign target  = {branch_target[31:2], 2'b00};
  assign bad_tgt = 1'b0;
  assign blocked = 1'b0;
`endif

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = in0;
  assign instr_pc    = pc0;
  assign op          = in0[6:0];
  assign funct3      = in0[14:12];
  assign funct7      = in0[30];
  assign pop         = instr_valid && instr_ready;
  assign count_after = count + 2'd1 - {1'b0, pop};

  // A response is still owed after this edge: must park in DROP on a redirect
  assign still_out = ((state == REQ) && imem_gnt) ||
                     (((state == WAIT) || (state == DROP)) && !imem_rvalid);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: if (!pc_src && !blocked && (count < 2'd2)) state_nxt = REQ;
      REQ:  if (imem_gnt) state_nxt = WAIT;
      WAIT: if (imem_rvalid) begin
        push      = !pc_src;
        state_nxt = (count_after < 2'd2) ? REQ : IDLE;
      end
      DROP: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (pc_src) state_nxt = still_out ? DROP : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if ((state == REQ) && imem_gnt) issued_pc <= fetch_pc;
      if (pc_src)
        fetch_pc <= target;
      else if ((state == REQ) && imem_gnt)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         misalign_err <= 1'b0;
    else if (pc_src) misalign_err <= bad_tgt;
  end
`endif

  // Shift FIFO: entry 0 is always the head, so the decode outputs come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      pc0   <= RESET_PC;
      pc1   <= RESET_PC;
      in0   <= 32'h0000_0013;
      in1   <= 32'h0000_0013;
    end else if (pc_src) begin
      count <= 2'd0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
      if (count == 2'd0) begin
        pc0 <= issued_pc;
        in0 <= imem_rdata;
      end else begin
        pc1 <= issued_pc;
        in1 <= imem_rdata;
      end
    end else if (pop && !push) begin
      count <= count - 2'd1;
      pc0   <= pc1;
      in0   <= in1;
    end else if (push && pop) begin
      if (count == 2'd1) begin
        pc0 <= issued_pc;
        in0 <= imem_rdata;
      end else begin
        pc0 <= pc1;
        in0 <= in1;
        pc1 <= issued_pc;
        in1 <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1- or 2-cycle instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        pc_src;
  logic [31:0] branch_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  logic        gnt_en, lat2;
  int          tests = 0;
  int          fails = 0;
  int          k, n, found;
  logic [31:0] gq[$];
  logic [31:0] cqp[$];
  logic [31:0] cqi[$];

  always #5 clk = ~clk;
  assign imem_gnt = imem_req & gnt_en;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .op(op), .funct3(funct3), .funct7(funct7),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .pc_src(pc_src), .branch_target(branch_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h4000_0033;
    return a + 32'h1000_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    pc_src        = 1'b1;
    branch_target = t;
    tick();
    pc_src        = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int c;
    c = 0;
    while (!(imem_req && imem_addr == a) && c < 60) begin
      tick();
      c++;
    end
    check(tag, imem_req ? imem_addr : 32'hDEAD_DEAD, a);
  endtask

  task automatic hold_reset(input logic l2);
    rst           = 1'b1;
    lat2          = l2;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    instr_ready   = 1'b1;
    gnt_en        = 1'b1;
    repeat (3) tick();
    gq.delete();
    cqp.delete();
    cqi.delete();
  endtask

  // Memory: grant is combinational, data returns 1 or 2 cycles after the grant
  initial begin
    logic        g, v0, v1;
    logic [31:0] a, a0, a1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    v0 = 1'b0; v1 = 1'b0; a0 = 32'h0; a1 = 32'h0;
    forever begin
      @(negedge clk);
      #3;
      g = imem_req && imem_gnt;
      a = imem_addr;
      @(posedge clk);
      #1;
      v1 = v0; a1 = a0;
      v0 = g;  a0 = a;
      imem_rvalid = lat2 ? v1 : v0;
      imem_rdata  = mem_word(lat2 ? a1 : a0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (imem_req && imem_gnt) gq.push_back(imem_addr);
        if (instr_valid && instr_ready) begin
          cqp.push_back(instr_pc);
          cqi.push_back(instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values and first-fetch latency
    hold_reset(1'b0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misalign", misalign_err, 0);
`endif
    rst = 1'b0;
    tick();
    check("a_req1", imem_req, 1);
    check("a_addr1", imem_addr, 32'h0);
    tick();
    check("a_valid_n2", instr_valid, 0);
    check("a_req_wait", imem_req, 0);
    tick();
    check("a_valid_n3", instr_valid, 1);
    check("a_pc_n3", instr_pc, 32'h0);
    check("a_instr_n3", instr, 32'h1000_0000);
    repeat (6) tick();
    check("a_ngrant", gq.size() >= 3, 1);
    check("a_ncons", cqp.size() >= 3, 1);
    if (gq.size() >= 3) begin
      check("a_g0", gq[0], 32'h0);
      check("a_g1", gq[1], 32'h4);
      check("a_g2", gq[2], 32'h8);
    end
    if (cqp.size() >= 3) begin
      check("a_c0", cqp[0], 32'h0);
      check("a_c1", cqp[1], 32'h4);
      check("a_c2", cqp[2], 32'h8);
      check("a_i2", cqi[2], 32'h1000_0008);
    end

    // Decode stalled: FIFO fills with 0x0, 0x4 and fetching stops
    hold_reset(1'b0);
    instr_ready = 1'b0;
    rst = 1'b0;
    repeat (10) tick();
    check("b_req", imem_req, 0);
    check("b_valid", instr_valid, 1);
    check("b_pc", instr_pc, 32'h0);
    check("b_ngrant", gq.size(), 2);
    instr_ready = 1'b1;
    tick();
    check("b_pc_next", instr_pc, 32'h4);
    check("b_instr_next", instr, 32'h1000_0004);
    tick();
    check("b_ncons", cqp.size() >= 2, 1);
    if (cqp.size() >= 2) begin
      check("b_c0", cqp[0], 32'h0);
      check("b_c1", cqp[1], 32'h4);
    end

    // Redirect in WAIT for 0x8 (2-cycle memory): 0x8 response dropped
    hold_reset(1'b1);
    rst = 1'b0;
    wait_req("c_req8", 32'h8);
    tick();
    redirect(32'h100);
    check("c_valid_flush", instr_valid, 0);
    check("c_req_drop", imem_req, 0);
    wait_req("c_req100", 32'h100);
    repeat (6) tick();
    check("c_ncons", cqp.size() >= 3, 1);
    if (cqp.size() >= 3) begin
      check("c_c1", cqp[1], 32'h4);
      check("c_c2", cqp[2], 32'h100);
      check("c_i2", cqi[2], 32'h1000_0100);
    end
    check("c_ngrant", gq.size() >= 4, 1);
    if (gq.size() >= 4) check("c_g3", gq[3], 32'h100);

    // Redirect in the grant cycle of 0x20 to 0x40
    hold_reset(1'b0);
    rst = 1'b0;
    wait_req("d_req20", 32'h20);
    redirect(32'h40);
    check("d_valid_flush", instr_valid, 0);
    check("d_req_drop", imem_req, 0);
    n = 0;
    while (!(instr_valid && instr_pc == 32'h40) && n < 60) begin
      tick();
      n++;
    end
    check("d_head_pc", instr_pc, 32'h40);
    check("d_instr", instr, 32'h4000_0033);
    check("d_op", op, 32'h33);
    check("d_funct3", funct3, 32'h0);
    check("d_funct7", funct7, 32'h1);
    k = -1;
    foreach (gq[i]) if (gq[i] == 32'h20 && k < 0) k = i;
    check("d_next_req", (k >= 0 && k + 1 < gq.size()) ? gq[k+1] : 32'hDEAD_DEAD, 32'h40);
    found = 0;
    foreach (cqp[i]) if (cqp[i] == 32'h20) found++;
    check("d_no20", found, 0);

    // PC wrap at the top of the address space
    hold_reset(1'b0);
    rst = 1'b0;
    tick();
    redirect(32'hFFFF_FFFC);
    repeat (10) tick();
    check("e_ngrant", gq.size() >= 3, 1);
    if (gq.size() >= 3) begin
      check("e_g1", gq[1], 32'hFFFF_FFFC);
      check("e_g2", gq[2], 32'h0);
    end
    check("e_ncons", cqp.size() >= 2, 1);
    if (cqp.size() >= 2) begin
      check("e_c0", cqp[0], 32'hFFFF_FFFC);
      check("e_i0", cqi[0], 32'h0FFF_FFFC);
      check("e_c1", cqp[1], 32'h0);
    end

    // No grant: address holds, redirect withdraws request for a cycle
    hold_reset(1'b0);
    gnt_en = 1'b0;
    rst = 1'b0;
    tick();
    check("f_req", imem_req, 1);
    repeat (3) tick();
    check("f_req_hold", imem_req, 1);
    check("f_addr_hold", imem_addr, 32'h0);
    redirect(32'h80);
    check("f_withdrawn", imem_req, 0);
    tick();
    check("f_req_tgt", imem_req, 1);
    check("f_addr_tgt", imem_addr, 32'h80);
    gnt_en = 1'b1;
    tick();

    // Misaligned redirect
    hold_reset(1'b0);
    rst = 1'b0;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect(32'h102);
    check("g_err_set", misalign_err, 1);
    check("g_req_off", imem_req, 0);
    repeat (6) tick();
    check("g_req_stuck", imem_req, 0);
    check("g_err_sticky", misalign_err, 1);
    check("g_ngrant", gq.size(), 1);
    redirect(32'h200);
    check("g_err_clr", misalign_err, 0);
    wait_req("g_req200", 32'h200);
`else
    redirect(32'h103);
    wait_req("g_req_forced", 32'h100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
